config_sr_driver: RTL and testbench
===================================

// Module: config_sr_driver
// PURPOSE
// - Drives the ASIC configuration shift register (config_sin/ck1/ck2/ld) from a 32-bit
//   word FIFO loaded over FTDI. Its outputs feed the config LVDS/SE output buffers in main_top.
// - Shifts bit_count bits MSB-first with non-overlapping two-phase clocks, then pulses load.
// - Optionally captures config_sout for shift-register readback.
// PARAMETERS
// - CNT_W   16  width of bit_count (max bits per transfer = 2^CNT_W-1)
// - DIV_W   8   width of clk_div
// PORTS
// - clk            in   1      system clock (100 MHz)
// - res_n          in   1      asynchronous active-low reset
// - start          in   1      1-cycle request to begin a transfer; ignored while busy
// - abort          in   1      synchronous abort, returns to IDLE
// - bit_count      in   CNT_W  number of bits to shift; latched on start
// - clk_div        in   DIV_W  phase length = clk_div+1 clk cycles; latched on start
// - fifo_dout      in   32     word from config write FIFO (standard read, 1-cycle latency)
// - fifo_empty     in   1      FIFO empty flag
// - fifo_rd_en     out  1      FIFO read strobe
// - config_sin     out  1      serial data to ASIC
// - config_ck1     out  1      phase-1 shift clock
// - config_ck2     out  1      phase-2 shift clock
// - config_ld      out  1      load strobe
// - config_sout    in   1      serial data returned from ASIC
// - rb_data        out  32     readback word
// - rb_wr_en       out  1      readback FIFO write strobe
// - rb_full        in   1      readback FIFO full
// - rb_overflow    out  1      sticky: readback word dropped
// - busy           out  1      high from state FETCH until DONE
// - done           out  1      1-cycle pulse at transfer end
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, counters 0. Asserting reset mid-transfer forces outputs
//   low immediately.
// - Reset and abort outputs: sin/ck1/ck2/ld=0.
// - States: IDLE, FETCH, LATCH, P0 (sin valid, clocks low), P1 (ck1=1), P2 (clocks low),
//   P3 (ck2=1), LDSET, LOAD (ld=1), DONE.
// - Each phase state lasts clk_div+1 cycles, so one bit takes 4*(clk_div+1) cycles.
// - IDLE + start, bit_count!=0: go to FETCH. IDLE + start, bit_count==0: go to DONE
//   (no clocks, no ld).
// - FETCH: fifo_rd_en = (state==FETCH) & ~fifo_empty (combinational). If empty, stall in
//   FETCH with all clocks low (no timeout).
// - LATCH: shift reg <= fifo_dout. Then go to P0. config_sin = shift reg[31].
// - After P3 the shift reg shifts left by 1 and the remaining count decrements.
//   - count==0: go to LDSET.
//   - 32 bits of the word consumed: go to FETCH.
//   - Otherwise: go to P0.
// - Final partial word: its unused low bits are discarded.
// - LDSET (clocks low) -> LOAD -> DONE (done=1 for 1 cycle) -> IDLE. busy=0 in DONE and IDLE.
// - abort has priority over every transition, including start in the same cycle: IDLE next
//   cycle, no done, no ld. A word already read from the FIFO is lost.
// - start during busy is ignored. clk_div/bit_count changes mid-transfer have no effect.
// - Counters are unsigned and do not wrap. bit_count=2^CNT_W-1 is legal.
// CONFIGURATION
// - CONFIG_SR_READBACK_EN defined:
//   - config_sout is sampled on the last cycle of each P3 and shifted into a 32-bit collector,
//     MSB-first.
//   - When 32 bits are collected, or at transfer end with a partial word (left-aligned,
//     zero-padded), rb_data is valid and rb_wr_en pulses for 1 cycle. This happens before
//     the transfer reaches LDSET.
//   - If rb_full at that cycle, the word is dropped and rb_overflow is set. rb_overflow is
//     cleared on the next accepted start.
// - CONFIG_SR_READBACK_EN undefined: the same ports exist; rb_data=0, rb_wr_en=0,
//   rb_overflow=0; config_sout is unused.
// TESTING
// - FIFO={0xA5000000}, bit_count=8, clk_div=0, start (sampled at edge 0):
//   - rd_en in cycle 1; sin = 1,0,1,0,0,1,0,1.
//   - 8 ck1 and 8 ck2 pulses, each 1 cycle wide, never overlapping.
//   - ld=1 in cycle 36; done=1 in cycle 37.
// - FIFO={0xFFFFFFFF, 0x80000000}, bit_count=33, clk_div=3:
//   - 2 rd_en pulses; 33 ck1 pulses, each 4 cycles wide; last sin=1; single ld pulse.
// - FIFO empty, start, bit_count=4: stall in FETCH with clocks low. Push 0xF0000000 after
//   50 cycles: the transfer completes normally and done pulses once.
// - Transfer in progress: abort during P1, then res_n low during a second transfer.
//   - Outputs low; no done; IDLE.
//   - A following start runs normally.
// - bit_count=0, start: no rd_en, no clocks, no ld; done pulses in cycle 1.
// - CONFIG_SR_READBACK_EN, sout looped to sin delayed by one bit, bit_count=40:
//   - Two rb_wr_en pulses; the second word is left-aligned with its low 24 bits zero.
//   - Repeat with rb_full=1: rb_overflow=1; cleared by the next start.

Source files
------------

// File: rtl/config_sr_driver.sv
// config_sr_driver
// Streams 32-bit words from the configuration write FIFO into the ASIC
// configuration shift register. Bits go out MSB-first under two
// non-overlapping phase clocks (ck1/ck2), followed by a single load strobe.
// Optional readback of config_sout is built when CONFIG_SR_READBACK_EN is
// defined; otherwise the readback ports are tied low.
module config_sr_driver #(
  parameter int CNT_W = 16,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] bit_count,
  input  logic [DIV_W-1:0] clk_div,
  input  logic [31:0]      fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  output logic             config_sin,
  output logic             config_ck1,
  output logic             config_ck2,
  output logic             config_ld,
  input  logic             config_sout,
  output logic [31:0]      rb_data,
  output logic             rb_wr_en,
  input  logic             rb_full,
  output logic             rb_overflow,
  output logic             busy,
  output logic             done
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_P0,
    S_P1,
    S_P2,
    S_P3,
    S_LDSET,
    S_LOAD,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_phaseCnt;
  logic [CNT_W-1:0] r_bitsLeft;
  logic [4:0]       r_wordBit;
  logic [31:0]      r_shift;
  logic             r_ck1;
  logic             r_ck2;
  logic             r_ld;
  logic             r_done;
  logic             r_busy;
  logic             w_phaseEnd;
  logic             w_inPhase;
  logic             w_accept;
  logic             w_bitEnd;

  assign w_phaseEnd = (r_phaseCnt == r_div);
  assign w_inPhase  = (r_state == S_P0) || (r_state == S_P1) ||
                      (r_state == S_P2) || (r_state == S_P3);
  assign w_accept   = (r_state == S_IDLE) && start && !abort;
  assign w_bitEnd   = (r_state == S_P3) && w_phaseEnd && !abort;

  // State register
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; abort overrides every other transition
  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start) w_next = (bit_count == '0) ? S_DONE : S_FETCH;
        S_FETCH: if (!fifo_empty) w_next = S_LATCH;
        S_LATCH: w_next = S_P0;
        S_P0:    if (w_phaseEnd) w_next = S_P1;
        S_P1:    if (w_phaseEnd) w_next = S_P2;
        S_P2:    if (w_phaseEnd) w_next = S_P3;
        S_P3: begin
          if (w_phaseEnd) begin
            if (r_bitsLeft == CNT_W'(1)) begin
              w_next = S_LDSET;
            end else if (r_wordBit == 5'd31) begin
              w_next = S_FETCH;
            end else begin
              w_next = S_P0;
            end
          end
        end
        S_LDSET: w_next = S_LOAD;
        S_LOAD:  w_next = S_DONE;
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Transfer datapath: latched parameters, phase timer, bit counters, shift register
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_div      <= '0;
      r_phaseCnt <= '0;
      r_bitsLeft <= '0;
      r_wordBit  <= '0;
      r_shift    <= '0;
    end else if (abort) begin
      r_phaseCnt <= '0;
      r_bitsLeft <= '0;
      r_wordBit  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_bitsLeft <= bit_count;
            r_div      <= clk_div;
            r_phaseCnt <= '0;
            r_wordBit  <= '0;
          end
        end
        S_LATCH: begin
          r_shift    <= fifo_dout;
          r_phaseCnt <= '0;
        end
        S_P0, S_P1, S_P2, S_P3: begin
          if (w_phaseEnd) begin
            r_phaseCnt <= '0;
            if (r_state == S_P3) begin
              r_shift    <= {r_shift[30:0], 1'b0};
              r_bitsLeft <= r_bitsLeft - CNT_W'(1);
              r_wordBit  <= r_wordBit + 5'd1;
            end
          end else begin
            r_phaseCnt <= r_phaseCnt + DIV_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Clock, load and status outputs registered from the next state so the ASIC sees glitch-free levels
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_ck1  <= 1'b0;
      r_ck2  <= 1'b0;
      r_ld   <= 1'b0;
      r_done <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_ck1  <= (w_next == S_P1);
      r_ck2  <= (w_next == S_P3);
      r_ld   <= (w_next == S_LOAD);
      r_done <= (w_next == S_DONE);
      r_busy <= (w_next != S_IDLE) && (w_next != S_DONE);
    end
  end

  assign fifo_rd_en = (r_state == S_FETCH) && !fifo_empty;
  assign config_sin = w_inPhase && r_shift[31];
  assign config_ck1 = r_ck1;
  assign config_ck2 = r_ck2;
  assign config_ld  = r_ld;
  assign busy       = r_busy;
  assign done       = r_done;

`ifdef CONFIG_SR_READBACK_EN
  logic [31:0] r_rbShift;
  logic [31:0] w_rbWord;
  logic [4:0]  r_rbCnt;
  logic        r_rbOverflow;
  logic        w_rbLast;

  assign w_rbLast = (r_bitsLeft == CNT_W'(1)) || (r_rbCnt == 5'd31);

  // Collector word including the bit being sampled this cycle, placed MSB-first
  always_comb begin
    w_rbWord           = r_rbShift;
    w_rbWord[~r_rbCnt] = config_sout;
  end

  assign rb_wr_en    = w_bitEnd && w_rbLast && !rb_full;
  assign rb_data     = (w_bitEnd && w_rbLast) ? w_rbWord : '0;
  assign rb_overflow = r_rbOverflow;

  // Readback collector: samples sout at the end of each ck2 phase and flags dropped words
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_rbShift    <= '0;
      r_rbCnt      <= '0;
      r_rbOverflow <= 1'b0;
    end else if (w_accept) begin
      r_rbShift    <= '0;
      r_rbCnt      <= '0;
      r_rbOverflow <= 1'b0;
    end else if (abort) begin
      r_rbShift <= '0;
      r_rbCnt   <= '0;
    end else if (w_bitEnd) begin
      if (w_rbLast) begin
        r_rbShift <= '0;
        r_rbCnt   <= '0;
        if (rb_full) begin
          r_rbOverflow <= 1'b1;
        end
      end else begin
        r_rbShift <= w_rbWord;
        r_rbCnt   <= r_rbCnt + 5'd1;
      end
    end
  end
`else
  logic w_unused;

  assign w_unused    = config_sout ^ rb_full ^ w_accept ^ w_bitEnd;
  assign rb_data     = '0;
  assign rb_wr_en    = 1'b0;
  assign rb_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_config_sr_driver.sv
// Testbench for config_sr_driver: FIFO model, pulse monitor and scoreboards
// for serial data and readback words.
module tb_config_sr_driver;

  logic        clk = 1'b0;
  logic        res_n;
  logic        start;
  logic        abort;
  logic [15:0] bit_count;
  logic [7:0]  clk_div;
  logic [31:0] fifo_dout = '0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_en;
  logic        config_sin;
  logic        config_ck1;
  logic        config_ck2;
  logic        config_ld;
  logic        config_sout = 1'b0;
  logic [31:0] rb_data;
  logic        rb_wr_en;
  logic        rb_full;
  logic        rb_overflow;
  logic        busy;
  logic        done;

  int total = 0;
  int bad = 0;

  logic [31:0] fifoQ[$];
  logic        expSin[$];
  logic        obsSin[$];
  logic [31:0] expRb[$];
  logic [31:0] obsRb[$];

  int relCyc = 0, ck1Cnt = 0, ck2Cnt = 0, ck1MinW = 0, ck1MaxW = 0, curW1 = 0;
  int overlapCnt = 0, rdEnCnt = 0, rdEnFirst = -1, ldCnt = 0, ldCycle = -1;
  int doneCnt = 0, doneCycle = -1, busyInDone = 0, rbWrCnt = 0, rbLastCycle = -1;
  logic busyAt1 = 1'b0;
  logic prevCk1 = 1'b0, prevCk2 = 1'b0, curSin = 1'b0;

  config_sr_driver #(.CNT_W(16), .DIV_W(8)) dut (
    .clk(clk), .res_n(res_n), .start(start), .abort(abort),
    .bit_count(bit_count), .clk_div(clk_div),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .config_sin(config_sin), .config_ck1(config_ck1), .config_ck2(config_ck2),
    .config_ld(config_ld), .config_sout(config_sout),
    .rb_data(rb_data), .rb_wr_en(rb_wr_en), .rb_full(rb_full),
    .rb_overflow(rb_overflow), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Standard-read FIFO with one cycle of read latency
  always @(posedge clk) begin
    if (fifo_rd_en && fifoQ.size() > 0) fifo_dout <= fifoQ.pop_front();
    fifo_empty <= (fifoQ.size() == 0);
  end

  // ASIC model: sout returns the bit shifted in one bit earlier
  always @(posedge config_ck1) curSin = config_sin;
  always @(negedge config_ck2) config_sout = curSin;

  // Monitor sampling one time unit after each rising edge
  always begin
    @(posedge clk);
    #1;
    relCyc++;
    if (relCyc == 1) busyAt1 = busy;
    if (config_ck1 && !prevCk1) begin ck1Cnt++; obsSin.push_back(config_sin); end
    if (config_ck1) curW1++;
    else if (prevCk1) begin
      if (ck1MinW == 0 || curW1 < ck1MinW) ck1MinW = curW1;
      if (curW1 > ck1MaxW) ck1MaxW = curW1;
      curW1 = 0;
    end
    if (config_ck2 && !prevCk2) ck2Cnt++;
    if (config_ck1 && config_ck2) overlapCnt++;
    if (fifo_rd_en) begin rdEnCnt++; if (rdEnFirst < 0) rdEnFirst = relCyc; end
    if (config_ld) begin ldCnt++; ldCycle = relCyc; end
    if (done) begin doneCnt++; doneCycle = relCyc; if (busy) busyInDone++; end
    if (rb_wr_en) begin rbWrCnt++; rbLastCycle = relCyc; obsRb.push_back(rb_data); end
    prevCk1 = config_ck1;
    prevCk2 = config_ck2;
  end

  task automatic pushExpected(input logic [31:0] w0, input logic [31:0] w1, input int bc);
    logic [31:0] w;
    for (int i = 0; i < bc; i++) begin
      w = (i < 32) ? w0 : w1;
      expSin.push_back(w[31 - (i % 32)]);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] bc, input logic [7:0] div);
    @(negedge clk);
    relCyc = 0; ck1Cnt = 0; ck2Cnt = 0; ck1MinW = 0; ck1MaxW = 0; curW1 = 0;
    overlapCnt = 0; rdEnCnt = 0; rdEnFirst = -1; ldCnt = 0; ldCycle = -1;
    doneCnt = 0; doneCycle = -1; busyInDone = 0; rbWrCnt = 0; rbLastCycle = -1;
    obsSin.delete(); obsRb.delete();
    bit_count = bc; clk_div = div; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input int budget, output bit timedOut);
    timedOut = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (doneCnt > 0) begin timedOut = 1'b0; break; end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    res_n = 1'b0; start = 1'b0; abort = 1'b0; bit_count = '0; clk_div = '0; rb_full = 1'b0;
    repeat (3) @(negedge clk);
    total++; if ({config_ck1, config_ck2, config_ld, config_sin} !== 4'b0) begin bad++; $display("[TB] FAIL reset_cfg_outs: got %b want 0000", {config_ck1, config_ck2, config_ld, config_sin}); end
    total++; if ({busy, done, fifo_rd_en} !== 3'b0) begin bad++; $display("[TB] FAIL reset_status: got %b want 000", {busy, done, fifo_rd_en}); end
    total++; if ({rb_wr_en, rb_overflow} !== 2'b0 || rb_data !== 32'h0) begin bad++; $display("[TB] FAIL reset_rb: got %b/%h want 00/0", {rb_wr_en, rb_overflow}, rb_data); end
    res_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic;
    bit to;
    logic e, o;
    expSin.delete();
    pushExpected(32'hA500_0000, 32'h0, 8);
    @(negedge clk); fifoQ.push_back(32'hA500_0000);
    applyStimulus(16'd8, 8'd0);
    waitDone(200, to);
    total++; if (to !== 1'b0) begin bad++; $display("[TB] FAIL basic_timeout: got %b want 0", to); end
    total++; if (busyAt1 !== 1'b1) begin bad++; $display("[TB] FAIL basic_busy_c1: got %b want 1", busyAt1); end
    total++; if (rdEnCnt !== 1 || rdEnFirst !== 1) begin bad++; $display("[TB] FAIL basic_rd_en: got cnt %0d cyc %0d want 1/1", rdEnCnt, rdEnFirst); end
    total++; if (ck1Cnt !== 8 || ck2Cnt !== 8) begin bad++; $display("[TB] FAIL basic_clk_count: got %0d/%0d want 8/8", ck1Cnt, ck2Cnt); end
    total++; if (ck1MinW !== 1 || ck1MaxW !== 1) begin bad++; $display("[TB] FAIL basic_ck1_width: got %0d..%0d want 1", ck1MinW, ck1MaxW); end
    total++; if (overlapCnt !== 0) begin bad++; $display("[TB] FAIL basic_overlap: got %0d want 0", overlapCnt); end
    total++; if (ldCnt !== 1 || ldCycle !== 36) begin bad++; $display("[TB] FAIL basic_ld: got cnt %0d cyc %0d want 1/36", ldCnt, ldCycle); end
    total++; if (doneCnt !== 1 || doneCycle !== 37) begin bad++; $display("[TB] FAIL basic_done: got cnt %0d cyc %0d want 1/37", doneCnt, doneCycle); end
    total++; if (busyInDone !== 0) begin bad++; $display("[TB] FAIL basic_busy_in_done: got %0d want 0", busyInDone); end
    total++; if (obsSin.size() !== expSin.size()) begin bad++; $display("[TB] FAIL basic_sin_count: got %0d want %0d", obsSin.size(), expSin.size()); end
    while (expSin.size() > 0 && obsSin.size() > 0) begin
      e = expSin.pop_front(); o = obsSin.pop_front();
      total++; if (o !== e) begin bad++; $display("[TB] FAIL basic_sin_bit: got %b want %b", o, e); end
    end
`ifndef CONFIG_SR_READBACK_EN
    total++; if (rbWrCnt !== 0) begin bad++; $display("[TB] FAIL basic_rb_idle: got %0d want 0", rbWrCnt); end
`endif
  endtask

  task automatic test_multiword;
    bit to;
    logic e, o, lastSin;
    expSin.delete();
    pushExpected(32'hFFFF_FFFF, 32'h8000_0000, 33);
    @(negedge clk); fifoQ.push_back(32'hFFFF_FFFF); fifoQ.push_back(32'h8000_0000);
    applyStimulus(16'd33, 8'd3);
    waitDone(2000, to);
    lastSin = (obsSin.size() > 0) ? obsSin[obsSin.size() - 1] : 1'b0;
    total++; if (to !== 1'b0) begin bad++; $display("[TB] FAIL multi_timeout: got %b want 0", to); end
    total++; if (rdEnCnt !== 2) begin bad++; $display("[TB] FAIL multi_rd_en: got %0d want 2", rdEnCnt); end
    total++; if (ck1Cnt !== 33 || ck2Cnt !== 33) begin bad++; $display("[TB] FAIL multi_clk_count: got %0d/%0d want 33/33", ck1Cnt, ck2Cnt); end
    total++; if (ck1MinW !== 4 || ck1MaxW !== 4) begin bad++; $display("[TB] FAIL multi_ck1_width: got %0d..%0d want 4", ck1MinW, ck1MaxW); end
    total++; if (overlapCnt !== 0) begin bad++; $display("[TB] FAIL multi_overlap: got %0d want 0", overlapCnt); end
    total++; if (lastSin !== 1'b1) begin bad++; $display("[TB] FAIL multi_last_sin: got %b want 1", lastSin); end
    total++; if (ldCnt !== 1 || doneCnt !== 1) begin bad++; $display("[TB] FAIL multi_ld_done: got %0d/%0d want 1/1", ldCnt, doneCnt); end
    total++; if (obsSin.size() !== expSin.size()) begin bad++; $display("[TB] FAIL multi_sin_count: got %0d want %0d", obsSin.size(), expSin.size()); end
    while (expSin.size() > 0 && obsSin.size() > 0) begin
      e = expSin.pop_front(); o = obsSin.pop_front();
      total++; if (o !== e) begin bad++; $display("[TB] FAIL multi_sin_bit: got %b want %b", o, e); end
    end
  endtask

  task automatic test_stall;
    bit to;
    logic e, o;
    expSin.delete();
    pushExpected(32'hF000_0000, 32'h0, 4);
    applyStimulus(16'd4, 8'd0);
    repeat (50) @(negedge clk);
    total++; if (busy !== 1'b1 || rdEnCnt !== 0) begin bad++; $display("[TB] FAIL stall_busy: got busy %b rd %0d want 1/0", busy, rdEnCnt); end
    total++; if (ck1Cnt !== 0 || ck2Cnt !== 0 || ldCnt !== 0 || doneCnt !== 0) begin bad++; $display("[TB] FAIL stall_quiet: got ck1 %0d ck2 %0d ld %0d done %0d want 0", ck1Cnt, ck2Cnt, ldCnt, doneCnt); end
    fifoQ.push_back(32'hF000_0000);
    waitDone(200, to);
    total++; if (to !== 1'b0) begin bad++; $display("[TB] FAIL stall_timeout: got %b want 0", to); end
    total++; if (doneCnt !== 1 || ldCnt !== 1 || ck1Cnt !== 4 || rdEnCnt !== 1) begin bad++; $display("[TB] FAIL stall_resume: got done %0d ld %0d ck1 %0d rd %0d want 1/1/4/1", doneCnt, ldCnt, ck1Cnt, rdEnCnt); end
    total++; if (obsSin.size() !== expSin.size()) begin bad++; $display("[TB] FAIL stall_sin_count: got %0d want %0d", obsSin.size(), expSin.size()); end
    while (expSin.size() > 0 && obsSin.size() > 0) begin
      e = expSin.pop_front(); o = obsSin.pop_front();
      total++; if (o !== e) begin bad++; $display("[TB] FAIL stall_sin_bit: got %b want %b", o, e); end
    end
  endtask

  task automatic test_zero;
    bit to;
    @(negedge clk); fifoQ.push_back(32'hDEAD_BEEF);
    applyStimulus(16'd0, 8'd0);
    waitDone(20, to);
    total++; if (to !== 1'b0 || doneCnt !== 1 || doneCycle !== 1) begin bad++; $display("[TB] FAIL zero_done: got to %b cnt %0d cyc %0d want 0/1/1", to, doneCnt, doneCycle); end
    total++; if (rdEnCnt !== 0 || ck1Cnt !== 0 || ck2Cnt !== 0 || ldCnt !== 0) begin bad++; $display("[TB] FAIL zero_quiet: got rd %0d ck1 %0d ck2 %0d ld %0d want 0", rdEnCnt, ck1Cnt, ck2Cnt, ldCnt); end
    fifoQ.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_abort;
    bit to;
    bit seen;
    logic e, o;
    @(negedge clk); fifoQ.push_back(32'h1234_5678);
    applyStimulus(16'd16, 8'd1);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (config_ck1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    total++; if (seen !== 1'b1) begin bad++; $display("[TB] FAIL abort_reach_p1: got %b want 1", seen); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (10) @(negedge clk);
    total++; if ({config_ck1, config_ck2, config_ld, config_sin, busy} !== 5'b0) begin bad++; $display("[TB] FAIL abort_outs: got %b want 00000", {config_ck1, config_ck2, config_ld, config_sin, busy}); end
    total++; if (doneCnt !== 0 || ldCnt !== 0) begin bad++; $display("[TB] FAIL abort_no_done: got done %0d ld %0d want 0/0", doneCnt, ldCnt); end
    // start and abort together: abort wins
    doneCnt = 0;
    start = 1'b1; abort = 1'b1; bit_count = '0;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (doneCnt !== 0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL abort_vs_start: got done %0d busy %b want 0/0", doneCnt, busy); end
    // reset mid-transfer
    fifoQ.push_back(32'h0F0F_0F0F);
    applyStimulus(16'd16, 8'd1);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (ck1Cnt >= 3) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    total++; if (seen !== 1'b1) begin bad++; $display("[TB] FAIL rst_reach_bits: got %b want 1", seen); end
    res_n = 1'b0;
    #1;
    total++; if ({config_ck1, config_ck2, config_ld, config_sin, busy, fifo_rd_en} !== 6'b0) begin bad++; $display("[TB] FAIL rst_outs_low: got %b want 000000", {config_ck1, config_ck2, config_ld, config_sin, busy, fifo_rd_en}); end
    repeat (3) @(negedge clk);
    res_n = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (doneCnt !== 0 || ldCnt !== 0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_no_done: got done %0d ld %0d busy %b want 0/0/0", doneCnt, ldCnt, busy); end
    // following transfer runs normally
    expSin.delete();
    pushExpected(32'h3C00_0000, 32'h0, 8);
    fifoQ.push_back(32'h3C00_0000);
    applyStimulus(16'd8, 8'd0);
    waitDone(200, to);
    total++; if (to !== 1'b0 || doneCnt !== 1 || doneCycle !== 37 || ldCnt !== 1 || ck1Cnt !== 8) begin bad++; $display("[TB] FAIL after_rst_run: got to %b done %0d@%0d ld %0d ck1 %0d want 0/1@37/1/8", to, doneCnt, doneCycle, ldCnt, ck1Cnt); end
    total++; if (obsSin.size() !== expSin.size()) begin bad++; $display("[TB] FAIL after_rst_sin_count: got %0d want %0d", obsSin.size(), expSin.size()); end
    while (expSin.size() > 0 && obsSin.size() > 0) begin
      e = expSin.pop_front(); o = obsSin.pop_front();
      total++; if (o !== e) begin bad++; $display("[TB] FAIL after_rst_sin_bit: got %b want %b", o, e); end
    end
  endtask

  task automatic test_readback;
    bit to;
    logic [31:0] w0, w1, ge, go;
    logic soutInit;
    w0 = 32'hA5C3_0F96;
    w1 = 32'h5B00_0000;
    soutInit = config_sout;
    rb_full = 1'b0;
    expRb.delete();
    expRb.push_back({soutInit, w0[31:1]});
    expRb.push_back({w0[0], w1[31:25], 24'h0});
    fifoQ.push_back(w0); fifoQ.push_back(w1);
    applyStimulus(16'd40, 8'd0);
    waitDone(400, to);
    total++; if (to !== 1'b0 || ck1Cnt !== 40) begin bad++; $display("[TB] FAIL rb_run: got to %b ck1 %0d want 0/40", to, ck1Cnt); end
`ifdef CONFIG_SR_READBACK_EN
    total++; if (rbWrCnt !== 2) begin bad++; $display("[TB] FAIL rb_wr_count: got %0d want 2", rbWrCnt); end
    total++; if (!(rbLastCycle >= 0 && rbLastCycle < ldCycle)) begin bad++; $display("[TB] FAIL rb_before_ld: got rb %0d ld %0d", rbLastCycle, ldCycle); end
    while (expRb.size() > 0 && obsRb.size() > 0) begin
      ge = expRb.pop_front(); go = obsRb.pop_front();
      total++; if (go !== ge) begin bad++; $display("[TB] FAIL rb_word: got %h want %h", go, ge); end
    end
    total++; if (rb_overflow !== 1'b0) begin bad++; $display("[TB] FAIL rb_no_overflow: got %b want 0", rb_overflow); end
    rb_full = 1'b1;
    fifoQ.push_back(w0); fifoQ.push_back(w1);
    applyStimulus(16'd40, 8'd0);
    waitDone(400, to);
    rb_full = 1'b0;
    total++; if (to !== 1'b0 || rbWrCnt !== 0 || rb_overflow !== 1'b1) begin bad++; $display("[TB] FAIL rb_full_drop: got to %b wr %0d ovf %b want 0/0/1", to, rbWrCnt, rb_overflow); end
    applyStimulus(16'd0, 8'd0);
    waitDone(20, to);
    total++; if (rb_overflow !== 1'b0) begin bad++; $display("[TB] FAIL rb_ovf_clear: got %b want 0", rb_overflow); end
`else
    total++; if (rbWrCnt !== 0 || rb_overflow !== 1'b0 || rb_data !== 32'h0) begin bad++; $display("[TB] FAIL rb_disabled: got wr %0d ovf %b data %h want 0/0/0", rbWrCnt, rb_overflow, rb_data); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multiword();
    test_stall();
    test_zero();
    test_abort();
    test_readback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
